// File: rtl/fft4_pkg.sv
// Shared constants and types for the radix-4 butterfly arbiter: requester count,
// result buffer depth, vector lane layout and the in-flight tag.
package fft4_pkg;

  localparam int NUM_REQ   = 2;
  localparam int RES_DEPTH = 2;
  localparam int NUM_PTS   = 4;
  localparam int LANE_I    = 0;
  localparam int LANE_Q    = 1;
  localparam int CRED_W    = $clog2(RES_DEPTH + 1);

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  function automatic int vec_width(input int w);
    return NUM_PTS * 2 * w;
  endfunction

  // LSB of component (pt, lane) inside a packed {d3q,d3i,...,d0q,d0i} vector
  function automatic int comp_lsb(input int pt, input int lane, input int w);
    return (2 * pt + lane) * w;
  endfunction

endpackage

// File: rtl/fft4_res_fifo.sv
// Per-requester result buffer: RES_DEPTH-entry first-word-fall-through FIFO.
// The head entry is presented directly and holds steady until popped.
module fft4_res_fifo
  import fft4_pkg::*;
#(
  parameter int W = 128
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  localparam int AW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CW = $clog2(RES_DEPTH + 1);

  logic [RES_DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        push, pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop  = o_valid && i_ready;
  // a write into a full buffer lands in the slot the departing head frees
  assign push = i_wr_en && ((cnt_q != CW'(RES_DEPTH)) || pop);

  always_comb begin
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

  assign o_valid = (cnt_q != '0);
  assign o_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fft4_bf_arbiter.sv
// Shares one fixed-latency radix-4 butterfly between two requesters: credit-gated
// round-robin issue, owner tags tracking in-flight vectors, per-owner result buffers.
module fft4_bf_arbiter
  import fft4_pkg::*;
#(
  parameter int SIZE_DATA  = 16,
  parameter int BF_LATENCY = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_req0_valid,
  output logic                   o_req0_ready,
  input  logic [8*SIZE_DATA-1:0] i_req0_data,
  input  logic                   i_req1_valid,
  output logic                   o_req1_ready,
  input  logic [8*SIZE_DATA-1:0] i_req1_data,
  output logic                   o_bf_valid,
  output logic [8*SIZE_DATA-1:0] o_bf_data,
  input  logic                   i_bf_complete,
  input  logic [8*SIZE_DATA-1:0] i_bf_data,
  output logic                   o_res0_valid,
  input  logic                   i_res0_ready,
  output logic [8*SIZE_DATA-1:0] o_res0_data,
  output logic                   o_res1_valid,
  input  logic                   i_res1_ready,
  output logic [8*SIZE_DATA-1:0] o_res1_data,
  output logic                   o_err
);

  localparam int VW = vec_width(SIZE_DATA);

  logic [NUM_REQ-1:0]             req_valid, elig, gnt;
  logic [NUM_REQ-1:0]             res_valid, res_ready, pop, fifo_wr, restore;
  logic [NUM_REQ-1:0][VW-1:0]     req_data, res_data;
  logic [NUM_REQ-1:0][CRED_W-1:0] credit_q, credit_d;
  logic                           last_q, gnt_idx, any_gnt;
  logic                           bf_valid_q;
  logic [VW-1:0]                  bf_data_q;
  tag_t [BF_LATENCY:0]            tag_q;
  tag_t                           tag_out;
  logic                           err_q, err_d;

  assign req_valid = {i_req1_valid, i_req0_valid};
  assign req_data  = {i_req1_data, i_req0_data};
  assign res_ready = {i_res1_ready, i_res0_ready};

  // Tie breaks toward whoever was not granted last; otherwise the lone eligible wins.
  always_comb begin
    gnt = elig;
    if (&elig) gnt = last_q ? 2'b01 : 2'b10;
  end

  assign any_gnt = |gnt;
  assign gnt_idx = gnt[1];
  assign tag_out = tag_q[BF_LATENCY];

  // A complete without a tag and a tag without a complete are both protocol faults.
  assign err_d = err_q | (i_bf_complete ^ tag_out.valid);

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
    assign elig[k]     = i_rst_n && req_valid[k] && (credit_q[k] != '0);
    assign pop[k]      = res_valid[k] && res_ready[k];
    assign fifo_wr[k]  = i_bf_complete && tag_out.valid && (tag_out.owner == 1'(k));
    assign restore[k]  = !i_bf_complete && tag_out.valid && (tag_out.owner == 1'(k));
    assign credit_d[k] = credit_q[k] + CRED_W'(pop[k]) + CRED_W'(restore[k])
                         - CRED_W'(gnt[k]);

    fft4_res_fifo #(
      .W(VW)
    ) u_res_fifo (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wr_en   (fifo_wr[k]),
      .i_wr_data (i_bf_data),
      .o_valid   (res_valid[k]),
      .i_ready   (res_ready[k]),
      .o_data    (res_data[k])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      credit_q   <= {NUM_REQ{CRED_W'(RES_DEPTH)}};
      last_q     <= 1'b1;
      bf_valid_q <= 1'b0;
      bf_data_q  <= '0;
      tag_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      bf_valid_q <= any_gnt;
      err_q      <= err_d;
      if (any_gnt) begin
        last_q    <= gnt_idx;
        bf_data_q <= req_data[gnt_idx];
      end
      // stage BF_LATENCY lines up with i_bf_complete for the same vector
      tag_q[0] <= tag_t'{valid: any_gnt, owner: gnt_idx};
      for (int s = 1; s <= BF_LATENCY; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign o_req0_ready = gnt[0];
  assign o_req1_ready = gnt[1];
  assign o_bf_valid   = bf_valid_q;
  assign o_bf_data    = bf_data_q;
  assign o_res0_valid = res_valid[0];
  assign o_res1_valid = res_valid[1];
  assign o_res0_data  = res_data[0];
  assign o_res1_data  = res_data[1];
  assign o_err        = err_q;

endmodule

// File: tb/tb_fft4_bf_arbiter.sv
// Randomized bench for fft4_bf_arbiter: a forward radix-4 butterfly model with
// fault injection, plus a credit/round-robin/in-order scoreboard at negedge.
module tb_fft4_bf_arbiter;
  import fft4_pkg::*;

  localparam int SD  = 16;
  localparam int LAT = 1;
  localparam int VW  = 8 * SD;
  typedef logic [VW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic v0, v1, r0, r1, bf_cpl;
  vec_t d0, d1, bf_din;
  logic o_req0_ready, o_req1_ready, o_bf_valid, o_res0_valid, o_res1_valid, o_err;
  vec_t o_bf_data, o_res0_data, o_res1_data;

  int checks = 0;
  int failures = 0;

  vec_t q0[$], q1[$], issq[$];
  int   outn[2];
  logic lastg;
  logic mon_en;
  logic drop_arm, drop_now, stray;
  int   drop_own;
  vec_t bfp_d [LAT+1];
  logic bfp_v [LAT+1];

  always #5 clk = ~clk;

  fft4_bf_arbiter #(.SIZE_DATA(SD), .BF_LATENCY(LAT)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req0_valid  (v0),
    .o_req0_ready  (o_req0_ready),
    .i_req0_data   (d0),
    .i_req1_valid  (v1),
    .o_req1_ready  (o_req1_ready),
    .i_req1_data   (d1),
    .o_bf_valid    (o_bf_valid),
    .o_bf_data     (o_bf_data),
    .i_bf_complete (bf_cpl),
    .i_bf_data     (bf_din),
    .o_res0_valid  (o_res0_valid),
    .i_res0_ready  (r0),
    .o_res0_data   (o_res0_data),
    .o_res1_valid  (o_res1_valid),
    .i_res1_ready  (r1),
    .o_res1_data   (o_res1_data),
    .o_err         (o_err)
  );

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t mk(int i0, int q0_, int i1, int q1_, int i2, int q2_, int i3, int q3_);
    int a[8];
    a = '{i0, q0_, i1, q1_, i2, q2_, i3, q3_};
    mk = '0;
    for (int k = 0; k < 8; k++) mk[SD*k +: SD] = SD'(a[k]);
  endfunction

  // Forward 4-point DFT: X[m] = sum_n x[n] * (-j)^(m*n)
  function automatic vec_t bf4(vec_t v);
    int xi[4], xq[4];
    for (int k = 0; k < 4; k++) begin
      xi[k] = int'($signed(v[comp_lsb(k, LANE_I, SD) +: SD]));
      xq[k] = int'($signed(v[comp_lsb(k, LANE_Q, SD) +: SD]));
    end
    bf4 = mk(xi[0] + xi[1] + xi[2] + xi[3], xq[0] + xq[1] + xq[2] + xq[3],
             xi[0] + xq[1] - xi[2] - xq[3], xq[0] - xi[1] - xq[2] + xi[3],
             xi[0] - xi[1] + xi[2] - xi[3], xq[0] - xq[1] + xq[2] - xq[3],
             xi[0] - xq[1] - xi[2] + xq[3], xq[0] + xi[1] - xq[2] - xi[3]);
  endfunction

  function automatic vec_t rndv();
    vec_t r;
    for (int k = 0; k < VW / 32; k++) r[32*k +: 32] = $urandom();
    return r;
  endfunction

  // Butterfly model: returns bf4 of each issued vector LAT cycles after o_bf_valid.
  always begin
    @(posedge clk); #1;
    for (int k = LAT; k > 0; k--) begin
      bfp_v[k] = bfp_v[k-1];
      bfp_d[k] = bfp_d[k-1];
    end
    bfp_v[0] = o_bf_valid;
    bfp_d[0] = o_bf_data;
    if (o_bf_valid && rst_n) begin
      chk("bf_issue_known", vec_t'(issq.size() > 0), vec_t'(1));
      if (issq.size() > 0) chk("bf_data", o_bf_data, issq.pop_front());
    end
    drop_now = 1'b0;
    if (!rst_n) begin
      for (int k = 0; k <= LAT; k++) bfp_v[k] = 1'b0;
      bf_cpl = 1'b0;
    end else if (stray) begin
      bf_cpl = 1'b1;
      bf_din = rndv();
      stray  = 1'b0;
    end else if (bfp_v[LAT] && drop_arm) begin
      bf_cpl   = 1'b0;
      drop_now = 1'b1;
      drop_arm = 1'b0;
    end else begin
      bf_cpl = bfp_v[LAT];
      bf_din = bf4(bfp_d[LAT]);
    end
  end

  // Scoreboard: credits are 2 minus outstanding vectors; ties go to the one not granted last.
  always @(negedge clk) begin
    logic e0, e1, x0, x1;
    if (mon_en && rst_n) begin
      e0 = v0 && (outn[0] < 2);
      e1 = v1 && (outn[1] < 2);
      x0 = e0 && (!e1 || lastg);
      x1 = e1 && (!e0 || !lastg);
      chk("ready0", vec_t'(o_req0_ready), vec_t'(x0));
      chk("ready1", vec_t'(o_req1_ready), vec_t'(x1));
      if (drop_now) begin
        outn[drop_own]--;
        if (drop_own == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      if (v0 && o_req0_ready) begin
        q0.push_back(bf4(d0)); issq.push_back(d0); outn[0]++; lastg = 1'b0;
      end
      if (v1 && o_req1_ready) begin
        q1.push_back(bf4(d1)); issq.push_back(d1); outn[1]++; lastg = 1'b1;
      end
      if (o_res0_valid && r0) begin
        chk("res0_expected", vec_t'(q0.size() > 0), vec_t'(1));
        if (q0.size() > 0) chk("res0_data", o_res0_data, q0.pop_front());
        outn[0]--;
      end
      if (o_res1_valid && r1) begin
        chk("res1_expected", vec_t'(q1.size() > 0), vec_t'(1));
        if (q1.size() > 0) chk("res1_data", o_res1_data, q1.pop_front());
        outn[1]--;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    q0.delete(); q1.delete(); issq.delete();
    outn[0] = 0; outn[1] = 0;
    lastg = 1'b1; drop_arm = 1'b0; stray = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    v0 = 1'b0; v1 = 1'b0; r0 = 1'b1; r1 = 1'b1;
    while ((q0.size() + q1.size() + issq.size()) != 0 && n < 100) begin
      tick(); n++;
    end
    chk("drain_empty", vec_t'(q0.size() + q1.size() + issq.size()), vec_t'(0));
    tick(); tick();
  endtask

  initial begin
    int n, c0, c1, sent;
    logic a0, a1;
    int gseq[8];
    rst_n = 1'b0; mon_en = 1'b0; drop_arm = 1'b0; drop_now = 1'b0; stray = 1'b0;
    drop_own = 0; lastg = 1'b1; outn[0] = 0; outn[1] = 0;
    v0 = 1'b1; v1 = 1'b1; r0 = 1'b1; r1 = 1'b1; d0 = rndv(); d1 = rndv();
    bf_cpl = 1'b0; bf_din = '0;

    // reset state, with requests asserted to show ready stays low
    repeat (2) @(posedge clk); #2;
    chk("rst_ready0", vec_t'(o_req0_ready), vec_t'(0));
    chk("rst_ready1", vec_t'(o_req1_ready), vec_t'(0));
    chk("rst_bf_valid", vec_t'(o_bf_valid), vec_t'(0));
    chk("rst_bf_data", o_bf_data, '0);
    chk("rst_res0_valid", vec_t'(o_res0_valid), vec_t'(0));
    chk("rst_res1_valid", vec_t'(o_res1_valid), vec_t'(0));
    chk("rst_res0_data", o_res0_data, '0);
    chk("rst_err", vec_t'(o_err), vec_t'(0));
    v0 = 1'b0; v1 = 1'b0;
    do_reset();

    // single vector, known transform, latency T+3 with LAT=1
    v0 = 1'b1; d0 = mk(1, 0, 2, 0, 3, 0, 4, 0);
    @(negedge clk);
    chk("sv_ready", vec_t'(o_req0_ready), vec_t'(1));
    tick(); v0 = 1'b0;
    n = 0;
    while (!o_res0_valid && n < 10) begin @(negedge clk); n++; end
    chk("sv_latency", vec_t'(n), vec_t'(3));
    chk("sv_result", o_res0_data, mk(10, 0, -2, 2, -2, 0, -2, -2));
    chk("sv_err", vec_t'(o_err), vec_t'(0));
    drain();

    // contention from reset: grants alternate starting with requester 0
    do_reset();
    v0 = 1'b1; v1 = 1'b1; d0 = rndv(); d1 = rndv();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a0 = o_req0_ready; a1 = o_req1_ready;
      gseq[i] = a1 ? 1 : (a0 ? 0 : 2);
      tick();
      if (a0) d0 = rndv();
      if (a1) d1 = rndv();
    end
    for (int i = 0; i < 8; i++) chk("rr_seq", vec_t'(gseq[i]), vec_t'(i % 2));
    drain();

    // backpressure on requester 0: only two accepts, requester 1 keeps flowing
    r0 = 1'b0; v0 = 1'b1; v1 = 1'b1; c0 = 0; c1 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a0 = o_req0_ready; a1 = o_req1_ready;
      c0 += int'(a0); c1 += int'(a1);
      tick();
      if (a0) d0 = rndv();
      if (a1) d1 = rndv();
    end
    chk("bp_acc0", vec_t'(c0), vec_t'(2));
    chk("bp_acc1_flowing", vec_t'(c1 >= 4), vec_t'(1));
    @(negedge clk);
    chk("bp_ready0_low", vec_t'(o_req0_ready), vec_t'(0));
    chk("bp_res0_held", vec_t'(o_res0_valid), vec_t'(1));
    tick();
    r0 = 1'b1; v1 = 1'b0; c0 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a0 = o_req0_ready; c0 += int'(a0);
      tick();
      if (a0) d0 = rndv();
    end
    chk("bp_resume", vec_t'(c0 >= 2), vec_t'(1));
    drain();

    // random traffic with random result backpressure
    sent = 0;
    for (int i = 0; i < 600 && sent < 120; i++) begin
      @(negedge clk);
      a0 = v0 && o_req0_ready; a1 = v1 && o_req1_ready;
      sent += int'(a0) + int'(a1);
      tick();
      if (!v0 || a0) begin v0 = ($urandom_range(0, 3) != 0); d0 = rndv(); end
      if (!v1 || a1) begin v1 = ($urandom_range(0, 3) != 0); d1 = rndv(); end
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 2) != 0);
    end
    chk("rnd_sent", vec_t'(sent >= 100), vec_t'(1));
    drain();
    chk("rnd_err", vec_t'(o_err), vec_t'(0));

    // stray complete with nothing in flight
    stray = 1'b1;
    repeat (3) tick();
    chk("stray_err", vec_t'(o_err), vec_t'(1));
    chk("stray_no_res0", vec_t'(o_res0_valid), vec_t'(0));
    chk("stray_no_res1", vec_t'(o_res1_valid), vec_t'(0));
    do_reset();
    chk("err_cleared", vec_t'(o_err), vec_t'(0));

    // dropped complete: error, no result, credit comes back
    drop_arm = 1'b1; drop_own = 0;
    v0 = 1'b1; d0 = rndv();
    @(negedge clk);
    tick(); v0 = 1'b0;
    repeat (5) tick();
    chk("drop_err", vec_t'(o_err), vec_t'(1));
    chk("drop_no_res", vec_t'(o_res0_valid), vec_t'(0));
    r0 = 1'b0; v0 = 1'b1; c0 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a0 = o_req0_ready; c0 += int'(a0);
      tick();
      if (a0) d0 = rndv();
    end
    chk("drop_credit", vec_t'(c0), vec_t'(2));
    drain();
    chk("drop_err_sticky", vec_t'(o_err), vec_t'(1));

    // async reset with one result buffered and two vectors in flight
    do_reset();
    r0 = 1'b0; v0 = 1'b1; d0 = rndv();
    @(negedge clk);
    tick(); v0 = 1'b0;
    n = 0;
    while (!o_res0_valid && n < 10) begin tick(); n++; end
    chk("ar_buffered", vec_t'(o_res0_valid), vec_t'(1));
    v0 = 1'b1; v1 = 1'b1; d0 = rndv(); d1 = rndv();
    repeat (2) begin
      @(negedge clk);
      a0 = o_req0_ready; a1 = o_req1_ready;
      tick();
      if (a0) begin v0 = 1'b0; d0 = rndv(); end
      if (a1) begin v1 = 1'b0; d1 = rndv(); end
    end
    mon_en = 1'b0; v0 = 1'b0; v1 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("ar_bf_valid", vec_t'(o_bf_valid), vec_t'(0));
    chk("ar_bf_data", o_bf_data, '0);
    chk("ar_res0_valid", vec_t'(o_res0_valid), vec_t'(0));
    chk("ar_res0_data", o_res0_data, '0);
    chk("ar_res1_valid", vec_t'(o_res1_valid), vec_t'(0));
    chk("ar_res1_data", o_res1_data, '0);
    chk("ar_err", vec_t'(o_err), vec_t'(0));
    do_reset();
    r0 = 1'b0; r1 = 1'b0; v0 = 1'b1; v1 = 1'b1; c0 = 0; c1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a0 = o_req0_ready; a1 = o_req1_ready;
      c0 += int'(a0); c1 += int'(a1);
      tick();
      if (a0) d0 = rndv();
      if (a1) d1 = rndv();
    end
    chk("ar_credit0", vec_t'(c0), vec_t'(2));
    chk("ar_credit1", vec_t'(c1), vec_t'(2));
    drain();
    chk("ar_no_err", vec_t'(o_err), vec_t'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
